// File: rtl/ram_pkg.sv
//==============================================================================
// Module      : ram_pkg
// Description : Shared constants for the RAM responder: default geometry and
//               latency, RW encoding, handshake FSM state encoding and the
//               byte-read extension helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ram_pkg;

    // Default geometry and latency
    localparam int DEF_DEPTH       = 512;
    localparam int DEF_WAIT_CYCLES = 2;

    // RW encoding
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Handshake FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widen a read byte to 32 bits, zero- or sign-extended
    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
        return uns ? {24'd0, b} : {{24{b[7]}}, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_byte_array.sv
//==============================================================================
// Module      : ram_byte_array
// Description : DEPTH x 8 byte storage. One combinational 4-byte read port and
//               one byte-enable 4-byte write port, both addressed by the byte
//               address of lane 0. wr_be[k] / rd_data lane k refer to byte
//               base+k, with byte base+0 in bits 31:24 (big-endian).
//               Contents are not reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_byte_array #(
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_base,
    input  logic [3:0]                 wr_be,
    input  logic [31:0]                wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [31:0]                rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] r_mem [DEPTH];

    // Byte-enabled write of up to four consecutive bytes
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) begin
                    r_mem[wr_base | AW'(l)] <= wr_data[31 - 8*l -: 8];
                end
            end
        end
    end

    // Combinational read of four consecutive bytes, base byte in the MSBs
    always_comb begin
        rd_data = 32'd0;
        for (int l = 0; l < 4; l++) begin
            rd_data[31 - 8*l -: 8] = r_mem[rd_base | AW'(l)];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
//==============================================================================
// Module      : ram_responder
// Description : Memory responder with a memEnable/MOC handshake. A request is
//               captured in IDLE, held for WAIT_CYCLES edges in BUSY, then
//               committed; MOC stays high in DONE until memEnable drops.
//               Byte-addressed, big-endian storage with address wrap.
//               The byte/word select port is named byteAcc because "byte" is a
//               reserved word.
//               Optional macro RAM_ALIGN_CHECK_EN adds the alignErr output and
//               suppresses misaligned word accesses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ram_responder
    import ram_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memEnable,
    input  logic        RW,
    input  logic        byteAcc,
    input  logic        unSign,
    input  logic [31:0] address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
`ifdef RAM_ALIGN_CHECK_EN
    output logic        alignErr,
`endif
    output logic        MOC
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WAIT_CYCLES) + 1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic          r_rw;
    logic          r_byte;
    logic          r_uns;
    logic [31:0]   r_din;
    logic          r_moc;
    logic [31:0]   r_dout;
    logic          r_align_err;

    logic          w_commit;
    logic          w_misalign;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_base;
    logic [31:0]   w_rd_word;
    logic [7:0]    w_rd_byte;
    logic [31:0]   w_rd_result;

    // Access commits on the edge where the countdown has reached zero
    assign w_commit = (r_state == ST_BUSY) && memEnable && (r_cnt == '0);

`ifdef RAM_ALIGN_CHECK_EN
    assign w_misalign = !r_byte && (r_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Word accesses ignore the low address bits; byte accesses pick one lane
    assign w_base  = r_addr & ~AW'(3);
    assign w_we    = w_commit && (r_rw == RW_WRITE) && !w_misalign;
    assign w_be    = r_byte ? (4'b0001 << r_addr[1:0]) : 4'b1111;
    assign w_wdata = r_byte ? {4{r_din[7:0]}} : r_din;

    ram_byte_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_we),
        .wr_base (w_base),
        .wr_be   (w_be),
        .wr_data (w_wdata),
        .rd_base (w_base),
        .rd_data (w_rd_word)
    );

    // Select the addressed byte lane and form the read result
    always_comb begin
        w_rd_byte = w_rd_word[31:24];
        case (r_addr[1:0])
            2'd0:    w_rd_byte = w_rd_word[31:24];
            2'd1:    w_rd_byte = w_rd_word[23:16];
            2'd2:    w_rd_byte = w_rd_word[15:8];
            default: w_rd_byte = w_rd_word[7:0];
        endcase
        if (w_misalign) begin
            w_rd_result = 32'd0;
        end else if (r_byte) begin
            w_rd_result = extend_byte(w_rd_byte, r_uns);
        end else begin
            w_rd_result = w_rd_word;
        end
    end

    // Handshake FSM: capture, countdown, commit, hold MOC until release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_rw        <= RW_READ;
            r_byte      <= 1'b0;
            r_uns       <= 1'b0;
            r_din       <= 32'd0;
            r_moc       <= 1'b0;
            r_dout      <= 32'd0;
            r_align_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (memEnable) begin
                        r_addr  <= address[AW-1:0];
                        r_rw    <= RW;
                        r_byte  <= byteAcc;
                        r_uns   <= unSign;
                        r_din   <= dataIn;
                        r_cnt   <= CW'(WAIT_CYCLES - 1);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!memEnable) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_moc       <= 1'b1;
                        r_align_err <= w_misalign;
                        r_state     <= ST_DONE;
                        if (r_rw == RW_READ) begin
                            r_dout <= w_rd_result;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!memEnable) begin
                        r_moc       <= 1'b0;
                        r_align_err <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dataOut = r_dout;
    assign MOC     = r_moc;
`ifdef RAM_ALIGN_CHECK_EN
    assign alignErr = r_align_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
//==============================================================================
// Module      : tb_ram_responder
// Description : Self-checking bench for ram_responder with a byte-array
//               reference model. Honours RAM_ALIGN_CHECK_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ram_responder;

    localparam int DEPTH = 512;
    localparam int WAIT  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memEnable;
    logic        RW;
    logic        byteAcc;
    logic        unSign;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        MOC;
`ifdef RAM_ALIGN_CHECK_EN
    logic        alignErr;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: plain byte array plus last read value
    logic [7:0]  model [DEPTH];
    logic [31:0] model_dout;

    ram_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memEnable (memEnable),
        .RW        (RW),
        .byteAcc   (byteAcc),
        .unSign    (unSign),
        .address   (address),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
`ifdef RAM_ALIGN_CHECK_EN
        .alignErr  (alignErr),
`endif
        .MOC       (MOC)
    );

    always #5 clk = ~clk;

    function automatic logic dut_err();
`ifdef RAM_ALIGN_CHECK_EN
        return alignErr;
`else
        return 1'b0;
`endif
    endfunction

    // Apply one access to the model; returns the expected alignment error
    task automatic ref_access(input logic rw, input logic byt, input logic uns,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic exp_err);
        int b;
        int w;
        logic [7:0] m;
        b = int'(a % DEPTH);
        w = b - (b % 4);
        exp_err = 1'b0;
`ifdef RAM_ALIGN_CHECK_EN
        if (!byt && (a % 4) != 0) begin
            exp_err = 1'b1;
            if (!rw) model_dout = 32'd0;
            return;
        end
`endif
        if (rw) begin
            if (byt) model[b] = d[7:0];
            else for (int k = 0; k < 4; k++) model[w + k] = d[31 - 8*k -: 8];
        end else if (byt) begin
            m = model[b];
            model_dout = uns ? {24'd0, m} : {{24{m[7]}}, m};
        end else begin
            model_dout = {model[w], model[w+1], model[w+2], model[w+3]};
        end
    endtask

    // Drive one full handshake; request fields are scrambled after capture
    task automatic access(input logic rw, input logic byt, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input int hold,
                          output int lat, output logic [31:0] dout, output logic err,
                          output bit hold_ok, output bit clr_ok);
        int n;
        @(negedge clk);
        memEnable = 1'b1; RW = rw; byteAcc = byt; unSign = uns; address = a; dataIn = d;
        @(posedge clk); #1;
        RW = 1'($urandom); byteAcc = 1'($urandom); unSign = 1'($urandom);
        address = $urandom; dataIn = $urandom;
        lat = -1;
        n = 0;
        while (lat < 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (MOC === 1'b1) lat = n;
        end
        dout = dataOut;
        err = dut_err();
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (MOC !== 1'b1 || dataOut !== dout) hold_ok = 1'b0;
        end
        @(negedge clk);
        memEnable = 1'b0;
        @(posedge clk); #1;
        clr_ok = (MOC === 1'b0) && (dut_err() === 1'b0);
    endtask

    task automatic test_reset();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        reset = 1'b0; memEnable = 1'b0; RW = 1'b0; byteAcc = 1'b0; unSign = 1'b0;
        address = '0; dataIn = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (MOC !== 1'b0) begin fails++; $display("FAIL reset_moc: got %b expected 0", MOC); end
        tests++; if (dataOut !== 32'd0) begin fails++; $display("FAIL reset_dout: got %h expected 0", dataOut); end
        @(negedge clk); reset = 1'b1;
        model_dout = 32'd0;
        for (int i = 0; i < DEPTH; i += 4) begin
            access(1'b1, 1'b0, 1'b0, 32'(i), 32'd0, 0, lat, dout, err, h, c);
            ref_access(1'b1, 1'b0, 1'b0, 32'(i), 32'd0, e);
        end
        tests++; if (dout !== 32'd0) begin fails++; $display("FAIL init_dout: got %h expected 0", dout); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 0, lat, dout, err, h, c);
        ref_access(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, e);
        tests++; if (lat !== WAIT) begin fails++; $display("FAIL wr_latency: got %0d expected %0d", lat, WAIT); end
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL wr_dout_hold: got %h expected %h", dout, model_dout); end
        tests++; if (!c) begin fails++; $display("FAIL wr_moc_clear: got 1 expected 0"); end
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, lat, dout, err, h, c);
        ref_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, e);
        tests++; if (lat !== WAIT) begin fails++; $display("FAIL rd_latency: got %0d expected %0d", lat, WAIT); end
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL rd_word: got %h expected %h", dout, model_dout); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        logic [31:0] addrs [3] = '{32'h10, 32'h10, 32'h13};
        logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b1, unss[i], addrs[i], 32'h0, 0, lat, dout, err, h, c);
            ref_access(1'b0, 1'b1, unss[i], addrs[i], 32'h0, e);
            tests++; if (dout !== model_dout) begin fails++; $display("FAIL byte_rd%0d: got %h expected %h", i, dout, model_dout); end
        end
        access(1'b1, 1'b1, 1'b0, 32'h11, 32'hAAAAAA55, 0, lat, dout, err, h, c);
        ref_access(1'b1, 1'b1, 1'b0, 32'h11, 32'hAAAAAA55, e);
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, lat, dout, err, h, c);
        ref_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, e);
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL byte_wr: got %h expected %h", dout, model_dout); end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] dout; logic err, e; bit h, c, rose;
        // Abort by dropping memEnable on the would-be commit edge
        @(negedge clk);
        memEnable = 1'b1; RW = 1'b1; byteAcc = 1'b0; unSign = 1'b0;
        address = 32'h20; dataIn = 32'h12345678;
        @(posedge clk); @(posedge clk);
        @(negedge clk); memEnable = 1'b0;
        rose = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (MOC !== 1'b0) rose = 1'b1; end
        tests++; if (rose) begin fails++; $display("FAIL abort_moc: got 1 expected 0"); end
        access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 0, lat, dout, err, h, c);
        ref_access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, e);
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL abort_rd: got %h expected %h", dout, model_dout); end
        // Make dataOut non-zero, then reset in the middle of a write
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 0, lat, dout, err, h, c);
        ref_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, e);
        @(negedge clk);
        memEnable = 1'b1; RW = 1'b1; byteAcc = 1'b0; address = 32'h20; dataIn = 32'h12345678;
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b0;
        #1;
        tests++; if (MOC !== 1'b0 || dataOut !== 32'd0) begin fails++;
            $display("FAIL rst_busy: got moc=%b dout=%h expected moc=0 dout=0", MOC, dataOut); end
        model_dout = 32'd0;
        @(negedge clk); memEnable = 1'b0;
        @(negedge clk); reset = 1'b1;
        access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 0, lat, dout, err, h, c);
        ref_access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, e);
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL rst_rd: got %h expected %h", dout, model_dout); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        logic [31:0] addrs [2] = '{32'h10 + 32'(DEPTH), 32'h12};
        for (int i = 0; i < 2; i++) begin
            access(1'b0, 1'b0, 1'b0, addrs[i], 32'h0, 0, lat, dout, err, h, c);
            ref_access(1'b0, 1'b0, 1'b0, addrs[i], 32'h0, e);
            tests++; if (dout !== model_dout) begin fails++; $display("FAIL wrap_rd%0d: got %h expected %h", i, dout, model_dout); end
`ifdef RAM_ALIGN_CHECK_EN
            tests++; if (err !== e) begin fails++; $display("FAIL wrap_err%0d: got %b expected %b", i, err, e); end
            tests++; if (!c) begin fails++; $display("FAIL wrap_errclr%0d: got 1 expected 0", i); end
`endif
        end
    endtask

    task automatic test_hold();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        access(1'b0, 1'b1, 1'b1, 32'h12, 32'h0, 5, lat, dout, err, h, c);
        ref_access(1'b0, 1'b1, 1'b1, 32'h12, 32'h0, e);
        tests++; if (!h) begin fails++; $display("FAIL hold_moc: got drop expected steady 1"); end
        tests++; if (!c) begin fails++; $display("FAIL hold_release: got 1 expected 0"); end
        tests++; if (dout !== model_dout) begin fails++; $display("FAIL hold_dout: got %h expected %h", dout, model_dout); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] dout; logic err, e; bit h, c;
        logic rw, byt, uns; logic [31:0] a, d;
        for (int i = 0; i < 60; i++) begin
            rw  = 1'($urandom); byt = 1'($urandom); uns = 1'($urandom);
            a   = ($urandom & ~32'(DEPTH - 1)) | 32'($urandom_range(0, 47));
            d   = $urandom;
            access(rw, byt, uns, a, d, int'($urandom_range(0, 2)), lat, dout, err, h, c);
            ref_access(rw, byt, uns, a, d, e);
            tests++; if (lat !== WAIT || dout !== model_dout || !h || !c) begin fails++;
                $display("FAIL rand%0d: got lat=%0d dout=%h hold=%b clr=%b expected lat=%0d dout=%h hold=1 clr=1",
                         i, lat, dout, h, c, WAIT, model_dout); end
`ifdef RAM_ALIGN_CHECK_EN
            tests++; if (err !== e) begin fails++; $display("FAIL rand_err%0d: got %b expected %b", i, err, e); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_abort();
        test_wrap();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
